dcb_config_loader: RTL
======================

DCB_CONFIG_LOADER -- requirements
Module: dcb_config_loader

Interface
REQ-001 Parameter W, default 16, routing track width per side.
REQ-002 Parameter DATAIN, default 3, data-input ports served by the connection block.
REQ-003 Parameter DATAOUT, default 2, data-output ports served by the connection block.
REQ-004 Derived CW = W*(DATAIN+DATAOUT), config word width (80 at defaults); counter width SHALL be clog2(CW+1).
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cfg_start  input  1  request to begin a load, sampled each cycle.
REQ-008 cfg_bit  input  1  serial configuration data.
REQ-009 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-010 cfg_ready  output  1  loader accepts a bit this cycle.
REQ-011 cfg_out  output  1  daisy-chain serial output, registered.
REQ-012 c  output  CW  committed switch-control word for the connection block.
REQ-013 cfg_done  output  1  one-cycle pulse marking a commit.
REQ-014 busy  output  1  high while not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and COMMIT.
REQ-016 IDLE: cfg_ready=0, busy=0; cfg_start=1 -> SHIFT with bit counter cleared to 0.
REQ-017 SHIFT: cfg_ready=1, busy=1; a handshake SHALL occur on any cycle with cfg_valid=1 and cfg_ready=1.
REQ-018 On each handshake, shadow register SHALL shift left with cfg_bit into bit 0, cfg_out SHALL take the shadow's prior bit CW-1, and the counter SHALL increment.
REQ-019 cfg_valid=0 cycles in SHIFT SHALL leave shadow, counter and cfg_out unchanged.
REQ-020 The handshake that brings the counter to CW SHALL move the FSM to COMMIT on that edge.
REQ-021 COMMIT, one cycle: cfg_ready=0, busy=1, cfg_done=1; at its closing edge c SHALL load the shadow and the FSM SHALL return to IDLE.
REQ-022 Bit order: the first accepted bit SHALL land in c[CW-1] and the last in c[0].
REQ-023 c SHALL change only at the COMMIT edge; a partial load SHALL never reach c.
REQ-024 cfg_start=1 in SHIFT SHALL clear the counter and restart the load; a handshake in the same cycle SHALL count as bit 1 of the new load.
REQ-025 cfg_start in COMMIT SHALL be ignored; a new load needs cfg_start in IDLE.
REQ-026 cfg_bit and cfg_valid SHALL be ignored outside SHIFT.
REQ-027 The counter SHALL never exceed CW and SHALL not wrap.

Reset
REQ-028 rst_n=0 SHALL at once force state IDLE, counter 0, shadow 0, c all 0 (all switches open), cfg_out 0, cfg_ready 0, cfg_done 0, busy 0.
REQ-029 Reset mid-SHIFT or in COMMIT SHALL discard the partial load, leaving c at 0.
REQ-030 After rst_n deasserts, the block SHALL stay in IDLE until cfg_start.

Verification
REQ-031 Defaults, cfg_start, then 80 back-to-back valid bits of 0xA5 repeated MSB-first -> cfg_done high exactly the cycle after bit 80; after that edge c = 0xA5A5...A5 (80 bits); busy then low.
REQ-032 Same load with cfg_valid toggling 1,0,1,0 -> identical c; cfg_done 159 cycles after the first handshake; c holds its old value until then.
REQ-033 Load all-ones, then load all-zeros -> cfg_out emits 80 ones during the second load; final c = 0.
REQ-034 40 bits of 1, then cfg_start, then 80 bits of 0 -> a single cfg_done; c = 0.
REQ-035 Assert rst_n=0 after 50 bits -> c, cfg_out and busy drop to 0 immediately; cfg_done never pulses for that load.
REQ-036 cfg_valid pulsed in IDLE, and cfg_start pulsed during COMMIT -> no state change and no second load.

Source files
------------

// File: rtl/dcb_config_loader.sv
// Serial configuration loader for a connection block. Bits are shifted into a
// shadow register and committed to the switch-control word c in a single step,
// so the connection block never sees a partially loaded configuration.
module dcb_config_loader #(
  parameter int unsigned W       = 16,
  parameter int unsigned DATAIN  = 3,
  parameter int unsigned DATAOUT = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic                             cfg_bit,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  output logic                             cfg_out,
  output logic [W*(DATAIN+DATAOUT)-1:0]    c,
  output logic                             cfg_done,
  output logic                             busy
);

  localparam int unsigned CW   = W * (DATAIN + DATAOUT);
  localparam int unsigned CNTW = $clog2(CW + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_t;

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   shadow_q;
  logic            hs;

  // cfg_ready is only ever high in SHIFT, so it doubles as the state qualifier.
  assign hs = cfg_valid & cfg_ready;

  // Loader FSM with shadow register, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shadow_q  <= '0;
      c         <= '0;
      cfg_out   <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            state_q   <= StShift;
            cnt_q     <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StShift: begin
          if (hs) begin
            shadow_q <= {shadow_q[CW-2:0], cfg_bit};
            cfg_out  <= shadow_q[CW-1];
          end
          if (cfg_start) begin
            // Restart: a bit accepted in the same cycle is the first of the new load.
            cnt_q <= hs ? CNTW'(1) : '0;
          end else if (hs) begin
            if (cnt_q == CNTW'(CW - 1)) begin
              state_q   <= StCommit;
              cnt_q     <= CNTW'(CW);
              cfg_ready <= 1'b0;
              cfg_done  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        StCommit: begin
          c        <= shadow_q;
          state_q  <= StIdle;
          cfg_done <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          cfg_ready <= 1'b0;
          cfg_done  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
